// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : decode_queue
// Purpose  : RV32I decode stage feeding a circular FIFO of decoded entries.
// Revision : 1.0 - initial release
// ============================================================================
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int REG_W = 6,
    parameter int OP_W  = 6
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [31:0]              in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OP_W-1:0]          out_op,
    output logic [REG_W-1:0]         out_rd,
    output logic [REG_W-1:0]         out_rs1,
    output logic [REG_W-1:0]         out_rs2,
    output logic [31:0]              out_imm,
    output logic [31:0]              out_pc,
    output logic                     out_is_ls,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [REG_W-1:0]   c_NULL  = {1'b1, {(REG_W-1){1'b0}}};

    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;

    // Op code 0 is reserved for illegal entries.
    localparam logic [OP_W-1:0] c_OP_LUI   = OP_W'(1);
    localparam logic [OP_W-1:0] c_OP_AUIPC = OP_W'(2);
    localparam logic [OP_W-1:0] c_OP_JAL   = OP_W'(3);
    localparam logic [OP_W-1:0] c_OP_JALR  = OP_W'(4);
    localparam logic [OP_W-1:0] c_OP_BEQ   = OP_W'(5);
    localparam logic [OP_W-1:0] c_OP_BNE   = OP_W'(6);
    localparam logic [OP_W-1:0] c_OP_BLT   = OP_W'(7);
    localparam logic [OP_W-1:0] c_OP_BGE   = OP_W'(8);
    localparam logic [OP_W-1:0] c_OP_BLTU  = OP_W'(9);
    localparam logic [OP_W-1:0] c_OP_BGEU  = OP_W'(10);
    localparam logic [OP_W-1:0] c_OP_LB    = OP_W'(11);
    localparam logic [OP_W-1:0] c_OP_LH    = OP_W'(12);
    localparam logic [OP_W-1:0] c_OP_LW    = OP_W'(13);
    localparam logic [OP_W-1:0] c_OP_LBU   = OP_W'(14);
    localparam logic [OP_W-1:0] c_OP_LHU   = OP_W'(15);
    localparam logic [OP_W-1:0] c_OP_SB    = OP_W'(16);
    localparam logic [OP_W-1:0] c_OP_SH    = OP_W'(17);
    localparam logic [OP_W-1:0] c_OP_SW    = OP_W'(18);
    localparam logic [OP_W-1:0] c_OP_ADDI  = OP_W'(19);
    localparam logic [OP_W-1:0] c_OP_SLTI  = OP_W'(20);
    localparam logic [OP_W-1:0] c_OP_SLTIU = OP_W'(21);
    localparam logic [OP_W-1:0] c_OP_XORI  = OP_W'(22);
    localparam logic [OP_W-1:0] c_OP_ORI   = OP_W'(23);
    localparam logic [OP_W-1:0] c_OP_ANDI  = OP_W'(24);
    localparam logic [OP_W-1:0] c_OP_SLLI  = OP_W'(25);
    localparam logic [OP_W-1:0] c_OP_SRLI  = OP_W'(26);
    localparam logic [OP_W-1:0] c_OP_SRAI  = OP_W'(27);
    localparam logic [OP_W-1:0] c_OP_ADD   = OP_W'(28);
    localparam logic [OP_W-1:0] c_OP_SUB   = OP_W'(29);
    localparam logic [OP_W-1:0] c_OP_SLL   = OP_W'(30);
    localparam logic [OP_W-1:0] c_OP_SLT   = OP_W'(31);
    localparam logic [OP_W-1:0] c_OP_SLTU  = OP_W'(32);
    localparam logic [OP_W-1:0] c_OP_XOR   = OP_W'(33);
    localparam logic [OP_W-1:0] c_OP_SRL   = OP_W'(34);
    localparam logic [OP_W-1:0] c_OP_SRA   = OP_W'(35);
    localparam logic [OP_W-1:0] c_OP_OR    = OP_W'(36);
    localparam logic [OP_W-1:0] c_OP_AND   = OP_W'(37);

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic             is_ls;
        logic             illegal;
    } entry_t;

    entry_t               r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;

    logic [6:0]       w_opc;
    logic [2:0]       w_f3;
    logic [6:0]       w_f7;
    logic [REG_W-1:0] w_fld_rd, w_fld_rs1, w_fld_rs2;
    logic [31:0]      w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u, w_imm_sh;
    logic             w_ok;
    logic             w_ls;
    logic [OP_W-1:0]  w_op;
    logic [REG_W-1:0] w_rd, w_rs1, w_rs2;
    logic [31:0]      w_imm;
    entry_t           w_dec;
    entry_t           w_head;
    logic             w_enq;
    logic             w_deq;

    assign w_opc     = in_inst[6:0];
    assign w_f3      = in_inst[14:12];
    assign w_f7      = in_inst[31:25];
    assign w_fld_rd  = REG_W'(in_inst[11:7]);
    assign w_fld_rs1 = REG_W'(in_inst[19:15]);
    assign w_fld_rs2 = REG_W'(in_inst[24:20]);

    assign w_imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign w_imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign w_imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign w_imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    assign w_imm_u  = {in_inst[31:12], 12'b0};
    assign w_imm_sh = {27'b0, in_inst[24:20]};

    always_comb begin
        w_ok  = 1'b1;
        w_ls  = 1'b0;
        w_op  = '0;
        w_rd  = w_fld_rd;
        w_rs1 = w_fld_rs1;
        w_rs2 = w_fld_rs2;
        w_imm = '0;
        case (w_opc)
            c_OPC_LUI, c_OPC_AUIPC: begin
                w_op  = (w_opc == c_OPC_LUI) ? c_OP_LUI : c_OP_AUIPC;
                w_rs1 = c_NULL;
                w_rs2 = c_NULL;
                w_imm = w_imm_u;
            end
            c_OPC_JAL: begin
                w_op  = c_OP_JAL;
                w_rs1 = c_NULL;
                w_rs2 = c_NULL;
                w_imm = w_imm_j;
            end
            c_OPC_JALR: begin
                w_op  = c_OP_JALR;
                w_rs2 = c_NULL;
                w_imm = w_imm_i;
                w_ok  = (w_f3 == 3'b000);
            end
            c_OPC_BRANCH: begin
                w_rd  = c_NULL;
                w_imm = w_imm_b;
                case (w_f3)
                    3'b000:  w_op = c_OP_BEQ;
                    3'b001:  w_op = c_OP_BNE;
                    3'b100:  w_op = c_OP_BLT;
                    3'b101:  w_op = c_OP_BGE;
                    3'b110:  w_op = c_OP_BLTU;
                    3'b111:  w_op = c_OP_BGEU;
                    default: w_ok = 1'b0;
                endcase
            end
            c_OPC_LOAD: begin
                w_rs2 = c_NULL;
                w_imm = w_imm_i;
                w_ls  = 1'b1;
                case (w_f3)
                    3'b000:  w_op = c_OP_LB;
                    3'b001:  w_op = c_OP_LH;
                    3'b010:  w_op = c_OP_LW;
                    3'b100:  w_op = c_OP_LBU;
                    3'b101:  w_op = c_OP_LHU;
                    default: w_ok = 1'b0;
                endcase
            end
            c_OPC_STORE: begin
                w_rd  = c_NULL;
                w_imm = w_imm_s;
                w_ls  = 1'b1;
                case (w_f3)
                    3'b000:  w_op = c_OP_SB;
                    3'b001:  w_op = c_OP_SH;
                    3'b010:  w_op = c_OP_SW;
                    default: w_ok = 1'b0;
                endcase
            end
            c_OPC_OPIMM: begin
                w_rs2 = c_NULL;
                w_imm = w_imm_i;
                case (w_f3)
                    3'b000: w_op = c_OP_ADDI;
                    3'b010: w_op = c_OP_SLTI;
                    3'b011: w_op = c_OP_SLTIU;
                    3'b100: w_op = c_OP_XORI;
                    3'b110: w_op = c_OP_ORI;
                    3'b111: w_op = c_OP_ANDI;
                    3'b001: begin
                        w_op  = c_OP_SLLI;
                        w_imm = w_imm_sh;
                        w_ok  = (w_f7 == 7'b0000000);
                    end
                    default: begin
                        w_imm = w_imm_sh;
                        if (w_f7 == 7'b0000000)      w_op = c_OP_SRLI;
                        else if (w_f7 == 7'b0100000) w_op = c_OP_SRAI;
                        else                         w_ok = 1'b0;
                    end
                endcase
            end
            c_OPC_OP: begin
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'b000:  w_op = c_OP_ADD;
                        3'b001:  w_op = c_OP_SLL;
                        3'b010:  w_op = c_OP_SLT;
                        3'b011:  w_op = c_OP_SLTU;
                        3'b100:  w_op = c_OP_XOR;
                        3'b101:  w_op = c_OP_SRL;
                        3'b110:  w_op = c_OP_OR;
                        default: w_op = c_OP_AND;
                    endcase
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
                    w_op = c_OP_SUB;
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
                    w_op = c_OP_SRA;
                end else begin
                    w_ok = 1'b0;
                end
            end
            default: w_ok = 1'b0;
        endcase

        // Illegal entries carry a canonical payload so downstream only looks at the flag.
        if (!w_ok) begin
            w_op  = '0;
            w_rd  = c_NULL;
            w_rs1 = c_NULL;
            w_rs2 = c_NULL;
            w_imm = '0;
            w_ls  = 1'b0;
        end

        w_dec.op      = w_op;
        w_dec.rd      = w_rd;
        w_dec.rs1     = w_rs1;
        w_dec.rs2     = w_rs2;
        w_dec.imm     = w_imm;
        w_dec.pc      = in_pc;
        w_dec.is_ls   = w_ls;
        w_dec.illegal = !w_ok;
    end

    assign in_ready  = rst_in && rdy_in && !flush_in && (r_count < c_DEPTH);
    assign out_valid = rdy_in && (r_count != '0);
    assign w_enq     = in_valid && in_ready;
    assign w_deq     = out_valid && out_ready && !flush_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy_in) begin
            if (w_enq) begin
                r_mem[r_tail] <= w_dec;
                r_tail        <= r_tail + 1'b1;
            end
            if (w_deq) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head      = r_mem[r_head];
    assign out_op      = w_head.op;
    assign out_rd      = w_head.rd;
    assign out_rs1     = w_head.rs1;
    assign out_rs2     = w_head.rs2;
    assign out_imm     = w_head.imm;
    assign out_pc      = w_head.pc;
    assign out_is_ls   = w_head.is_ls;
    assign out_illegal = w_head.illegal;
    assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_queue
// Purpose  : Directed self-checking bench for decode_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_queue;

    localparam int DEPTH = 4;
    localparam int REG_W = 6;
    localparam int OP_W  = 6;
    localparam logic [REG_W-1:0] NR = 6'd32;

    localparam int NT = 9;
    localparam logic [31:0] T_INST [NT] = '{32'h00500093, 32'hFFC0A103, 32'h402081B3,
                                             32'h40335293, 32'h402091B3, 32'h0020A423,
                                             32'hFE208EE3, 32'h123452B7, 32'h00000000};
    localparam logic [5:0]  T_OP  [NT] = '{6'd19, 6'd13, 6'd29, 6'd27, 6'd0, 6'd18, 6'd5, 6'd1, 6'd0};
    localparam logic [5:0]  T_RD  [NT] = '{6'd1, 6'd2, 6'd3, 6'd5, NR, NR, NR, 6'd5, NR};
    localparam logic [5:0]  T_RS1 [NT] = '{6'd0, 6'd1, 6'd1, 6'd6, NR, 6'd1, 6'd1, NR, NR};
    localparam logic [5:0]  T_RS2 [NT] = '{NR, NR, 6'd2, NR, NR, 6'd2, 6'd2, NR, NR};
    localparam logic [31:0] T_IMM [NT] = '{32'd5, 32'hFFFFFFFC, 32'd0, 32'd3, 32'd0, 32'd8,
                                            32'hFFFFFFFC, 32'h12345000, 32'd0};
    localparam logic [NT-1:0] T_LS  = 9'b000100010;
    localparam logic [NT-1:0] T_ILL = 9'b100010000;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b0;
    logic              rdy_in = 1'b1;
    logic              flush_in = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_inst = '0;
    logic [31:0]       in_pc = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OP_W-1:0]   out_op;
    logic [REG_W-1:0]  out_rd, out_rs1, out_rs2;
    logic [31:0]       out_imm, out_pc;
    logic              out_is_ls, out_illegal;
    logic [2:0]        count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_in = ~clk_in;

    decode_queue #(.DEPTH(DEPTH), .REG_W(REG_W), .OP_W(OP_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_pc(out_pc),
        .out_is_ls(out_is_ls), .out_illegal(out_illegal), .count(count)
    );

    function automatic logic [31:0] addi_x1(input int v);
        addi_x1 = (32'(v) << 20) | 32'h00000093;
    endfunction

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
        @(negedge clk_in);
        in_valid = 1'b1; in_inst = inst; in_pc = pc;
        @(posedge clk_in); #1;
        in_valid = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk_in);
        out_ready = 1'b1;
        @(posedge clk_in); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_checks++; if ({out_op, out_rd, out_rs1, out_rs2, out_imm, out_pc, out_is_ls, out_illegal} !== '0) begin
            n_errors++; $display("FAIL reset_data got op=%0d rd=%0d imm=%h pc=%h exp all zero", out_op, out_rd, out_imm, out_pc);
        end
        @(negedge clk_in); rst_in = 1'b1;
        @(posedge clk_in); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_release_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_decode();
        for (int k = 0; k < NT; k++) begin
            offer(T_INST[k], 32'h1000 + 32'(4 * k));
            n_checks++; if (out_valid !== 1'b1 || count !== 3'd1) begin n_errors++; $display("FAIL dec%0d_valid got v=%b c=%0d exp v=1 c=1", k, out_valid, count); end
            n_checks++; if (out_op !== T_OP[k]) begin n_errors++; $display("FAIL dec%0d_op got=%0d exp=%0d", k, out_op, T_OP[k]); end
            n_checks++; if (out_rd !== T_RD[k]) begin n_errors++; $display("FAIL dec%0d_rd got=%0d exp=%0d", k, out_rd, T_RD[k]); end
            n_checks++; if (out_rs1 !== T_RS1[k]) begin n_errors++; $display("FAIL dec%0d_rs1 got=%0d exp=%0d", k, out_rs1, T_RS1[k]); end
            n_checks++; if (out_rs2 !== T_RS2[k]) begin n_errors++; $display("FAIL dec%0d_rs2 got=%0d exp=%0d", k, out_rs2, T_RS2[k]); end
            n_checks++; if (out_imm !== T_IMM[k]) begin n_errors++; $display("FAIL dec%0d_imm got=%h exp=%h", k, out_imm, T_IMM[k]); end
            n_checks++; if (out_is_ls !== T_LS[k] || out_illegal !== T_ILL[k]) begin
                n_errors++; $display("FAIL dec%0d_flags got ls=%b ill=%b exp ls=%b ill=%b", k, out_is_ls, out_illegal, T_LS[k], T_ILL[k]);
            end
            n_checks++; if (out_pc !== 32'h1000 + 32'(4 * k)) begin n_errors++; $display("FAIL dec%0d_pc got=%h exp=%h", k, out_pc, 32'h1000 + 32'(4 * k)); end
            pop();
            n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL dec%0d_pop got c=%0d v=%b exp c=0 v=0", k, count, out_valid); end
        end
    endtask

    task automatic test_order();
        offer(32'h008000EF, 32'h2000);
        offer(32'h00000000, 32'h2004);
        n_checks++; if (count !== 3'd2) begin n_errors++; $display("FAIL order_count got=%0d exp=2", count); end
        n_checks++; if (out_op !== 6'd3 || out_rd !== 6'd1 || out_illegal !== 1'b0) begin
            n_errors++; $display("FAIL order_jal_op got op=%0d rd=%0d ill=%b exp op=3 rd=1 ill=0", out_op, out_rd, out_illegal);
        end
        n_checks++; if (out_imm !== 32'd8 || out_rs1 !== NR || out_rs2 !== NR) begin
            n_errors++; $display("FAIL order_jal_fields got imm=%h rs1=%0d rs2=%0d exp imm=8 rs1=32 rs2=32", out_imm, out_rs1, out_rs2);
        end
        pop();
        n_checks++; if (out_illegal !== 1'b1 || out_pc !== 32'h2004 || out_op !== 6'd0) begin
            n_errors++; $display("FAIL order_illegal got ill=%b pc=%h op=%0d exp ill=1 pc=2004 op=0", out_illegal, out_pc, out_op);
        end
        pop();
    endtask

    task automatic test_full();
        for (int i = 1; i <= DEPTH; i++) offer(addi_x1(i), 32'h3000 + 32'(4 * i));
        @(negedge clk_in);
        in_valid = 1'b1; in_inst = addi_x1(5); in_pc = 32'h3014;
        @(posedge clk_in); #1;
        n_checks++; if (count !== 3'd4) begin n_errors++; $display("FAIL full_count got=%0d exp=4", count); end
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        @(negedge clk_in); out_ready = 1'b1;
        @(posedge clk_in); #1; out_ready = 1'b0;
        n_checks++; if (count !== 3'd3) begin n_errors++; $display("FAIL full_pop_no_enq got=%0d exp=3", count); end
        @(posedge clk_in); #1; in_valid = 1'b0;
        n_checks++; if (count !== 3'd4) begin n_errors++; $display("FAIL full_late_enq got=%0d exp=4", count); end
        for (int k = 2; k <= 5; k++) begin
            n_checks++; if (out_valid !== 1'b1 || out_imm !== 32'(k)) begin
                n_errors++; $display("FAIL full_drain%0d got v=%b imm=%0d exp v=1 imm=%0d", k, out_valid, out_imm, k);
            end
            pop();
        end
        n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL full_empty got=%0d exp=0", count); end
    endtask

    task automatic test_back_to_back();
        offer(addi_x1(1), 32'h4000);
        @(negedge clk_in);
        in_valid = 1'b1; in_inst = addi_x1(2); in_pc = 32'h4004; out_ready = 1'b1;
        @(posedge clk_in); #1;
        n_checks++; if (count !== 3'd1 || out_imm !== 32'd2) begin n_errors++; $display("FAIL b2b_1 got c=%0d imm=%0d exp c=1 imm=2", count, out_imm); end
        @(negedge clk_in); in_inst = addi_x1(3); in_pc = 32'h4008;
        @(posedge clk_in); #1;
        n_checks++; if (count !== 3'd1 || out_imm !== 32'd3) begin n_errors++; $display("FAIL b2b_2 got c=%0d imm=%0d exp c=1 imm=3", count, out_imm); end
        @(negedge clk_in); in_valid = 1'b0;
        @(posedge clk_in); #1; out_ready = 1'b0;
        n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL b2b_drain got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 3; i++) offer(addi_x1(i), 32'h5000 + 32'(4 * i));
        @(negedge clk_in);
        in_valid = 1'b1; in_inst = addi_x1(9); flush_in = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        @(posedge clk_in); #1;
        flush_in = 1'b0; in_valid = 1'b0;
        n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_clear got c=%0d v=%b exp c=0 v=0", count, out_valid); end
        @(posedge clk_in); #1;
        n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL flush_dropped got=%0d exp=0", count); end
    endtask

    task automatic test_pause();
        offer(addi_x1(7), 32'h6000);
        offer(addi_x1(8), 32'h6004);
        @(negedge clk_in);
        rdy_in = 1'b0; in_valid = 1'b1; in_inst = addi_x1(9); out_ready = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_errors++; $display("FAIL pause_hs got v=%b r=%b exp v=0 r=0", out_valid, in_ready); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_in); #1;
            n_checks++; if (count !== 3'd2) begin n_errors++; $display("FAIL pause_count%0d got=%0d exp=2", c, count); end
        end
        @(negedge clk_in);
        rdy_in = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b1 || out_imm !== 32'd7) begin n_errors++; $display("FAIL pause_head got v=%b imm=%0d exp v=1 imm=7", out_valid, out_imm); end
        pop();
        n_checks++; if (out_imm !== 32'd8) begin n_errors++; $display("FAIL pause_next got=%0d exp=8", out_imm); end
        pop();
    endtask

    task automatic test_async_reset();
        offer(addi_x1(4), 32'h7000);
        offer(addi_x1(6), 32'h7004);
        @(negedge clk_in); #2;
        rst_in = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL arst_clear got c=%0d v=%b exp c=0 v=0", count, out_valid); end
        n_checks++; if (out_imm !== 32'd0 || out_pc !== 32'd0 || out_rd !== 6'd0) begin
            n_errors++; $display("FAIL arst_data got imm=%h pc=%h rd=%0d exp 0", out_imm, out_pc, out_rd);
        end
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL arst_in_ready got=%b exp=0", in_ready); end
        @(negedge clk_in); rst_in = 1'b1;
        @(posedge clk_in); #1;
        n_checks++; if (in_ready !== 1'b1 || count !== 3'd0) begin n_errors++; $display("FAIL arst_release got r=%b c=%0d exp r=1 c=0", in_ready, count); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_order();
        test_full();
        test_back_to_back();
        test_flush();
        test_pause();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
